// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline definitions: frame geometry, FSM encoding and the per-row tag
// that travels alongside each block row.
package jpeg_pkg;
    localparam int JPEG_ADDR_W     = 15;
    localparam int JPEG_DATA_W     = 64;
    localparam int JPEG_WPR        = 64;
    localparam int JPEG_BLK_ROWS   = 64;
    localparam int JPEG_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } jpeg_state_e;

    typedef struct packed {
        logic       frame_last;
        logic       blk_last;
        logic [2:0] idx;
    } jpeg_tag_t;
endpackage

// File: rtl/jpeg_row_fifo.sv
// Two-entry row buffer with count/full/empty; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module jpeg_row_fifo #(
    parameter int W = 69
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
endmodule

// File: rtl/jpeg_block_fetch.sv
// Walks the raster image in MEM_IN and streams it out as 8x8 blocks, one 64-bit row per
// transfer, with credit-based issue so the 2-entry row FIFO can never overflow.
module jpeg_block_fetch
    import jpeg_pkg::*;
#(
    parameter int ADDR_W   = JPEG_ADDR_W,
    parameter int DATA_W   = JPEG_DATA_W,
    parameter int WPR      = JPEG_WPR,
    parameter int BLK_ROWS = JPEG_BLK_ROWS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] blk_row,
    output logic              blk_row_valid,
    input  logic              blk_row_ready,
    output logic [2:0]        blk_row_idx,
    output logic              blk_last,
    output logic              frame_last
);
    localparam int BX_W = $clog2(WPR);
    localparam int FW   = DATA_W + $bits(jpeg_tag_t);

    jpeg_state_e       state_q;
    // Frame position as {by, bx, r}: a plain increment walks rows, then blocks, then block rows.
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q, vld_q;
    jpeg_tag_t         tag_req_q, tag_vld_q, tag_new, tag_out;
    logic              busy_q, done_q;

    logic [2:0]        r;
    logic [BX_W-1:0]   bx;
    logic [ADDR_W-BX_W-4:0] by;
    logic              pop, issue, last_blk, drained;
    logic [2:0]        occ;
    logic [1:0]        fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_dout;

    assign r        = pos_q[2:0];
    assign bx       = pos_q[BX_W+2:3];
    assign by       = pos_q[ADDR_W-1:BX_W+3];
    assign pos_d    = pos_q + ADDR_W'(1);
    assign last_blk = &pos_q[ADDR_W-1:3];
    assign tag_new  = '{frame_last: last_blk && (&r), blk_last: &r, idx: r};

    // Credits cover the address at the SRAM, the word coming back, and the FIFO contents.
    assign blk_row_valid = !fifo_empty;
    assign pop     = blk_row_valid && blk_row_ready;
    assign occ     = {1'b0, fifo_cnt} + {2'b0, req_q} + {2'b0, vld_q} - {2'b0, pop};
    assign issue   = (state_q == ST_FETCH) && !(fifo_full && !pop)
                     && (occ < 3'(JPEG_FIFO_DEPTH));
    assign drained = (fifo_empty || (fifo_cnt == 2'd1 && pop)) && !req_q && !vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            vld_q     <= 1'b0;
            tag_req_q <= '0;
            tag_vld_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            req_q     <= issue;
            vld_q     <= req_q;
            tag_vld_q <= tag_req_q;
            if (issue) begin
                addr_q    <= {by, r, bx};
                tag_req_q <= tag_new;
                pos_q     <= pos_d;
            end
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_FETCH;
                    busy_q  <= 1'b1;
                    pos_q   <= '0;
                end
                ST_FETCH: if (issue && (&pos_q)) state_q <= ST_DRAIN;
                ST_DRAIN: if (drained) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    jpeg_row_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (vld_q),
        .din_i   ({tag_vld_q, data_in}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tag_out     = jpeg_tag_t'(fifo_dout[FW-1:DATA_W]);
    assign blk_row     = fifo_dout[DATA_W-1:0];
    assign blk_row_idx = tag_out.idx;
    assign blk_last    = tag_out.blk_last;
    assign frame_last  = tag_out.frame_last;
    assign address_in  = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
